// File: rtl/mem_arb.sv
// mem_arb: two-port to one-port memory arbiter.
//
// Serialises instruction fetches (ifu_*) and load/store traffic (lsu_*) onto a
// single memory request/response channel. Each port owns one pending slot;
// the LSU wins when both are waiting. Responses return to the port that
// issued the request. A watchdog answers with ERR_DATA when memory stays
// silent for TIMEOUT cycles after a request was accepted.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   ifu_reqValid/addr   : fetch request pulse and address
//   ifu_respValid/rdata : fetch response pulse and data
//   lsu_reqValid/addr/size/wen/wdata/wmask : load/store request pulse and payload
//   lsu_respValid/rdata : load/store response pulse and data
//   mem_reqValid/Ready  : memory request handshake
//   mem_addr/size/wen/wdata/wmask : memory request payload
//   mem_respValid/rdata : memory response
//   timeout_err         : one-cycle pulse alongside a watchdog response
//   overflow            : sticky flag, a request hit an occupied port
module mem_arb #(
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        mem_reqValid,
    input  logic        mem_reqReady,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state;
    logic        sel_lsu;
    logic [7:0]  wd_count;

    logic        ifu_pend;
    logic [31:0] ifu_slot_addr;
    logic        lsu_pend;
    logic [31:0] lsu_slot_addr;
    logic [1:0]  lsu_slot_size;
    logic        lsu_slot_wen;
    logic [31:0] lsu_slot_wdata;
    logic [3:0]  lsu_slot_wmask;

    logic        ifu_busy;
    logic        lsu_busy;
    logic        accept;

    // A port is busy while its slot waits or while its transaction is the
    // one currently owned by the FSM (REQ or RESP).
    assign ifu_busy = ifu_pend || ((state != IDLE) && !sel_lsu);
    assign lsu_busy = lsu_pend || ((state != IDLE) && sel_lsu);
    assign accept   = (state == REQ) && mem_reqReady;

    // Pending slots: capture on a request pulse when the port is free, drop
    // and flag overflow otherwise, release when memory accepts the request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifu_pend       <= 1'b0;
            ifu_slot_addr  <= 32'h0;
            lsu_pend       <= 1'b0;
            lsu_slot_addr  <= 32'h0;
            lsu_slot_size  <= 2'b00;
            lsu_slot_wen   <= 1'b0;
            lsu_slot_wdata <= 32'h0;
            lsu_slot_wmask <= 4'b0000;
            overflow       <= 1'b0;
        end else begin
            if (accept && !sel_lsu) begin
                ifu_pend <= 1'b0;
            end
            if (accept && sel_lsu) begin
                lsu_pend <= 1'b0;
            end
            if (ifu_reqValid) begin
                if (ifu_busy) begin
                    overflow <= 1'b1;
                end else begin
                    ifu_pend      <= 1'b1;
                    ifu_slot_addr <= ifu_addr;
                end
            end
            if (lsu_reqValid) begin
                if (lsu_busy) begin
                    overflow <= 1'b1;
                end else begin
                    lsu_pend       <= 1'b1;
                    lsu_slot_addr  <= lsu_addr;
                    lsu_slot_size  <= lsu_size;
                    lsu_slot_wen   <= lsu_wen;
                    lsu_slot_wdata <= lsu_wdata;
                    lsu_slot_wmask <= lsu_wmask;
                end
            end
        end
    end

    // Arbitration FSM with registered memory payload and response outputs.
    // Response pulses default low so each one lasts exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sel_lsu       <= 1'b0;
            wd_count      <= 8'd0;
            mem_reqValid  <= 1'b0;
            mem_addr      <= 32'h0;
            mem_size      <= 2'b00;
            mem_wen       <= 1'b0;
            mem_wdata     <= 32'h0;
            mem_wmask     <= 4'b0000;
            ifu_respValid <= 1'b0;
            ifu_rdata     <= 32'h0;
            lsu_respValid <= 1'b0;
            lsu_rdata     <= 32'h0;
            timeout_err   <= 1'b0;
        end else begin
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            timeout_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_pend) begin
                        sel_lsu      <= 1'b1;
                        mem_addr     <= lsu_slot_addr;
                        mem_size     <= lsu_slot_size;
                        mem_wen      <= lsu_slot_wen;
                        mem_wdata    <= lsu_slot_wdata;
                        mem_wmask    <= lsu_slot_wmask;
                        mem_reqValid <= 1'b1;
                        state        <= REQ;
                    end else if (ifu_pend) begin
                        sel_lsu      <= 1'b0;
                        mem_addr     <= ifu_slot_addr;
                        mem_size     <= 2'b10;
                        mem_wen      <= 1'b0;
                        mem_wdata    <= 32'h0;
                        mem_wmask    <= 4'b0000;
                        mem_reqValid <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (mem_reqReady) begin
                        mem_reqValid <= 1'b0;
                        wd_count     <= 8'd0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // A real response wins over a watchdog expiry in the same cycle.
                    if (mem_respValid || (wd_count == TIMEOUT - 8'd1)) begin
                        if (sel_lsu) begin
                            lsu_respValid <= 1'b1;
                            lsu_rdata     <= mem_respValid ? mem_rdata : ERR_DATA;
                        end else begin
                            ifu_respValid <= 1'b1;
                            ifu_rdata     <= mem_respValid ? mem_rdata : ERR_DATA;
                        end
                        timeout_err <= !mem_respValid;
                        state       <= IDLE;
                    end else begin
                        wd_count <= wd_count + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port to one-port memory arbiter sitting directly downstream of the CPU core. It accepts instruction fetches on the core's `io_ifu_*` port and load/store traffic on its `io_lsu_*` port, then serialises them onto a single memory-side request/response channel. Responses are routed back to the originating port. A per-transaction watchdog returns an error word if memory never answers.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles to wait for `mem_respValid` after request acceptance before forcing an error response (8-bit counter).
- `ERR_DATA`, 32'hDEAD_BEEF: rdata returned on timeout.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `ifu_reqValid` in 1: fetch request pulse, one cycle.
- `ifu_addr` in 32: fetch address, valid with `ifu_reqValid`.
- `ifu_respValid` out 1: fetch response pulse.
- `ifu_rdata` out 32: fetch data, valid with `ifu_respValid`.
- `lsu_reqValid` in 1: load/store request pulse, one cycle.
- `lsu_addr` in 32, `lsu_size` in 2, `lsu_wen` in 1, `lsu_wdata` in 32, `lsu_wmask` in 4: LSU payload, valid with `lsu_reqValid`.
- `lsu_respValid` out 1, `lsu_rdata` out 32: LSU response pulse and data.
- `mem_reqValid` out 1, `mem_reqReady` in 1: memory request handshake.
- `mem_addr` out 32, `mem_size` out 2, `mem_wen` out 1, `mem_wdata` out 32, `mem_wmask` out 4: memory payload.
- `mem_respValid` in 1, `mem_rdata` in 32: memory response.
- `timeout_err` out 1: one-cycle pulse when a watchdog response is issued.
- `overflow` out 1: sticky; set when a request arrives on a port that already has one pending or in flight.

## Operation
- Per-port pending slot: `ifu_reqValid`/`lsu_reqValid` high captures the payload into that port's slot and sets its pending flag. IFU captures force size=2'b10, wen=0, wmask=4'b0000, wdata=0.
- Request on a port whose slot is pending or currently in flight: dropped, slot unchanged, `overflow` set until reset.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if LSU pending, select LSU; else if IFU pending, select IFU; go to REQ and load `mem_*` payload registers from the selected slot. Fixed priority LSU > IFU.
  - REQ: `mem_reqValid`=1, payload held stable. On `mem_reqReady`=1 clear selected pending flag, clear watchdog, go to RESP.
  - RESP: wait for `mem_respValid`. On it, register `mem_rdata` into selected port's rdata, pulse its respValid next cycle, go to IDLE. Watchdog increments each RESP cycle; reaching `TIMEOUT` without response: return `ERR_DATA` to owner, pulse `timeout_err`, go to IDLE.
- `mem_respValid` outside RESP: ignored.
- Stores also complete through `mem_respValid`; `lsu_rdata` carries whatever memory returns.
- Reset values: all outputs 0 (`mem_reqValid`, both respValids, all data/payload, `timeout_err`, `overflow`), FSM IDLE, pending flags clear, watchdog 0. Reset mid-transaction aborts it immediately; no response is ever issued for it.

## Timing
- Request pulse at cycle N: slot captured at edge ending N; FSM in REQ and `mem_reqValid`=1 at N+2 if idle (IDLE decision at N+1).
- `mem_reqReady` high in cycle M with `mem_reqValid`: accepted; RESP from M+1.
- `mem_respValid` in cycle R: owner respValid=1 and rdata valid in R+1, exactly one cycle. FSM back in IDLE at R+1; next pending request's `mem_reqValid` at R+2.
- Minimum round trip with ready tied high and 1-cycle memory: request N, response pulse N+4.
- Simultaneous IFU and LSU pulses: both captured; LSU issued first, IFU issued after LSU response.
- Request pulse for the idle port arriving while the other port is in flight: captured, served after completion.
- Watchdog: response at cycle RESP-entry+`TIMEOUT`, `timeout_err` coincident with the owner respValid.

## Test plan
- Single fetch, ready=1, 1-cycle memory returning 32'h0000_0013 for `ifu_addr`=32'h8000_0000: `mem_addr`=32'h8000_0000, size=2, wen=0, `ifu_respValid` pulse 4 cycles after request with rdata 32'h0000_0013; `lsu_respValid` stays 0.
- Store: `lsu_addr`=32'h8000_0100, wdata=32'hCAFE_F00D, wmask=4'b0011, size=1, wen=1; ready held low 3 cycles: payload stable throughout REQ, single `lsu_respValid` pulse after memory response.
- Same-cycle IFU (32'h8000_0004) and LSU (32'h8000_0200) pulses: memory sees 32'h8000_0200 first, then 32'h8000_0004; each response routed to its own port.
- Memory never responds, `TIMEOUT`=8: owner respValid with rdata 32'hDEAD_BEEF and `timeout_err` pulse 8 cycles after acceptance; next request proceeds normally.
- Second IFU pulse while first in flight: `overflow` goes 1 and stays; only one `ifu_respValid`.
- Drive reset low during RESP: all outputs 0 asynchronously; late `mem_respValid` after release produces no response.
